otter_exec_unit: RTL and testbench

Execute-stage datapath block for the OTTER RV32I multicycle MCU. It combines three functions:
- a 4-bit-opcode ALU;
- the branch-condition generator (eq / signed lt / unsigned lt of rs1 vs rs2);
- the branch-target generator (jal, branch, jalr targets).

All primary results are combinational, feeding the PC mux, register-file write mux and memory address. A clock-enabled result register provides a stable, registered copy of the ALU result and the flags for debug/IO use.

---
 rtl/otter_exec_unit.sv | 106 ++++++++++
 tb/tb_otter_exec_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/otter_exec_unit.sv
// OTTER RV32I execute-stage datapath: ALU, branch-condition generator,
// branch-target generator, and a clock-enabled capture register that holds
// the ALU result and the branch flags for debug/IO observation.
module otter_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      alu_fun,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] jtype_imm,
  input  logic [XLEN-1:0] btype_imm,
  input  logic [XLEN-1:0] itype_imm,
  input  logic            cap_en,
  output logic [XLEN-1:0] alu_result,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_ltu,
  output logic [XLEN-1:0] jal,
  output logic [XLEN-1:0] branch,
  output logic [XLEN-1:0] jalr,
  output logic [XLEN-1:0] alu_result_q,
  output logic [2:0]      flags_q
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Only the low five bits of srcB select a shift distance.
  logic [4:0]      shamt_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] alu_result_d;
  logic [2:0]      flags_d;

  assign shamt_s = srcB[4:0];

  // ALU operation decode; unused opcodes produce zero.
  always_comb begin
    alu_result = {XLEN{1'b0}};
    case (alu_fun)
      ALU_ADD:  alu_result = srcA + srcB;
      ALU_SUB:  alu_result = srcA - srcB;
      ALU_OR:   alu_result = srcA | srcB;
      ALU_AND:  alu_result = srcA & srcB;
      ALU_XOR:  alu_result = srcA ^ srcB;
      ALU_SLL:  alu_result = srcA << shamt_s;
      ALU_SRL:  alu_result = srcA >> shamt_s;
      ALU_SRA:  alu_result = $unsigned($signed(srcA) >>> shamt_s);
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (srcA < srcB)};
      ALU_LUI:  alu_result = srcA;
      default:  alu_result = {XLEN{1'b0}};
    endcase
  end

  // Branch conditions depend only on the register operands, never on alu_fun.
  always_comb begin
    br_eq  = (rs1 == rs2);
    br_lt  = ($signed(rs1) < $signed(rs2));
    br_ltu = (rs1 < rs2);
  end

  // Branch/jump targets; all sums wrap silently at 2^XLEN.
  always_comb begin
    jal        = pc + jtype_imm;
    branch     = pc + btype_imm;
    jalr_sum_s = rs1 + itype_imm;
    jalr       = {jalr_sum_s[XLEN-1:1], 1'b0};
  end

  // Next-state for the capture register: load on cap_en, otherwise hold.
  always_comb begin
    if (cap_en) begin
      alu_result_d = alu_result;
      flags_d      = {br_eq, br_lt, br_ltu};
    end else begin
      alu_result_d = alu_result_q;
      flags_d      = flags_q;
    end
  end

  // Capture register; reset wins over cap_en on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_result_q <= {XLEN{1'b0}};
      flags_q      <= 3'b000;
    end else begin
      alu_result_q <= alu_result_d;
      flags_q      <= flags_d;
    end
  end

endmodule

// File: tb/tb_otter_exec_unit.sv
// Directed self-checking bench for otter_exec_unit.
module tb_otter_exec_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  alu_fun;
  logic [31:0] srcA, srcB, pc, rs1, rs2;
  logic [31:0] jtype_imm, btype_imm, itype_imm;
  logic        cap_en;
  logic [31:0] alu_result, jal, branch, jalr, alu_result_q;
  logic        br_eq, br_lt, br_ltu;
  logic [2:0]  flags_q;

  int n_checks = 0;
  int n_pass   = 0;

  otter_exec_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .alu_fun(alu_fun), .srcA(srcA), .srcB(srcB),
    .pc(pc), .rs1(rs1), .rs2(rs2), .jtype_imm(jtype_imm),
    .btype_imm(btype_imm), .itype_imm(itype_imm), .cap_en(cap_en),
    .alu_result(alu_result), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .jal(jal), .branch(branch), .jalr(jalr),
    .alu_result_q(alu_result_q), .flags_q(flags_q)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    alu_fun = f; srcA = a; srcB = b;
    #1;
    check_val(tag, alu_result, exp);
  endtask

  task automatic br_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] exp);
    rs1 = a; rs2 = b;
    #1;
    check_val(tag, {29'd0, br_eq, br_lt, br_ltu}, {29'd0, exp});
  endtask

  initial begin
    RST = 1'b1; cap_en = 1'b0; alu_fun = 4'b0000;
    srcA = 32'd0; srcB = 32'd0; pc = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
    jtype_imm = 32'd0; btype_imm = 32'd0; itype_imm = 32'd0;

    // Reset state
    @(posedge CLK); #1;
    check_val("rst_res", alu_result_q, 32'h0000_0000);
    check_val("rst_flags", {29'd0, flags_q}, 32'd0);
    RST = 1'b0;

    // ALU arithmetic
    alu_vec("add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    alu_vec("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu_vec("sub_neg",  4'b1000, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);
    alu_vec("unused_f", 4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);
    alu_vec("unused_a", 4'b1010, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);

    // Logic, shift, compare
    alu_vec("or",   4'b0110, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    alu_vec("and",  4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    alu_vec("xor",  4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    alu_vec("sra4", 4'b1101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    alu_vec("srl4", 4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    alu_vec("sll31",4'b0001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
    alu_vec("sra_mask", 4'b1101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    alu_vec("srl_mask", 4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    alu_vec("sll_mask", 4'b0001, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010);
    alu_vec("slt",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    alu_vec("slt0", 4'b0010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    alu_vec("sltu", 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu_vec("sltu1",4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
    alu_vec("lui",  4'b1001, 32'h1234_5000, 32'hDEAD_BEEF, 32'h1234_5000);

    // Branch conditions
    br_vec("br_equal", 32'h0000_0055, 32'h0000_0055, 3'b100);
    br_vec("br_slt",   32'hFFFF_FFFF, 32'h0000_0001, 3'b010);
    br_vec("br_ultu",  32'h0000_0001, 32'hFFFF_FFFF, 3'b001);
    br_vec("br_both",  32'h0000_0002, 32'h0000_0009, 3'b011);

    // Branch targets
    pc = 32'h0000_0100; jtype_imm = 32'hFFFF_FFF0; btype_imm = 32'h0000_0008;
    rs1 = 32'h0000_0203; itype_imm = 32'h0000_0000;
    #1;
    check_val("jal",    jal,    32'h0000_00F0);
    check_val("branch", branch, 32'h0000_0108);
    check_val("jalr",   jalr,   32'h0000_0202);
    rs1 = 32'h0000_1000; itype_imm = 32'h0000_0005;
    #1;
    check_val("jalr_b0", jalr, 32'h0000_1004);
    pc = 32'hFFFF_FFFC; btype_imm = 32'h0000_0008;
    #1;
    check_val("branch_wrap", branch, 32'h0000_0004);

    // Register stage: capture ADD 3+4 with flags {0,1,0}
    @(negedge CLK);
    alu_fun = 4'b0000; srcA = 32'd3; srcB = 32'd4;
    rs1 = 32'hFFFF_FFFF; rs2 = 32'h0000_0001; cap_en = 1'b1;
    @(posedge CLK); #1;
    check_val("cap_res", alu_result_q, 32'd7);
    check_val("cap_flags", {29'd0, flags_q}, {29'd0, 3'b010});

    // Hold with new operands
    @(negedge CLK);
    cap_en = 1'b0; srcA = 32'd100; srcB = 32'd200; rs1 = 32'd5; rs2 = 32'd5;
    @(posedge CLK); #1;
    check_val("hold_res", alu_result_q, 32'd7);
    check_val("hold_flags", {29'd0, flags_q}, {29'd0, 3'b010});

    // Reset has priority over cap_en
    @(negedge CLK);
    RST = 1'b1; cap_en = 1'b1; srcA = 32'd9; srcB = 32'd1;
    @(posedge CLK); #1;
    check_val("rstpri_res", alu_result_q, 32'd0);
    check_val("rstpri_flags", {29'd0, flags_q}, 32'd0);
    check_val("rst_comb", alu_result, 32'd10);
    check_val("rst_comb_eq", {31'd0, br_eq}, 32'd1);

    // Capture again after reset release
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check_val("recap_res", alu_result_q, 32'd10);
    check_val("recap_flags", {29'd0, flags_q}, {29'd0, 3'b100});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
